// File: rtl/sdram_rom_server_pkg.sv
// sdram_rom_server_pkg
//   Shared types and constants for the SDRAM ROM server: the arbiter FSM
//   state enum, the requester port index enum, default word base addresses
//   of each ROM region, and the bus widths of the SDRAM-side interface.
package sdram_rom_server_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    M68K,
    TILES,
    SPR,
    THEME
  } port_t;

  localparam int NUM_PORTS  = 4;
  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 32;

  localparam logic [MEM_ADDR_W-1:0] DEF_M68K_BASE  = 24'h000000;
  localparam logic [MEM_ADDR_W-1:0] DEF_TILES_BASE = 24'h040000;
  localparam logic [MEM_ADDR_W-1:0] DEF_SPR_BASE   = 24'h080000;
  localparam logic [MEM_ADDR_W-1:0] DEF_THEME_BASE = 24'h100000;

  // Region base plus offset; the 24-bit result wraps naturally.
  function automatic logic [MEM_ADDR_W-1:0] region_addr(
    input logic [MEM_ADDR_W-1:0] base,
    input logic [MEM_ADDR_W-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

// File: rtl/sdram_rom_server_if.sv
// sdram_rom_server_if
//   Word-addressed read bus between the ROM server and the SDRAM controller.
//   mem_req   : read request, held high until mem_rdy
//   mem_addr  : 24-bit 32-bit-word address, stable while mem_req is high
//   mem_rdy   : one-cycle data-valid strobe from the controller
//   mem_dout  : 32-bit read data, valid with mem_rdy
//   master modport : the ROM server side; slave modport : the controller side
interface sdram_rom_server_if;
  import sdram_rom_server_pkg::*;

  logic                  mem_req;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_rdy;
  logic [MEM_DATA_W-1:0] mem_dout;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdy,
    input  mem_dout
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdy,
    output mem_dout
  );

endinterface

// File: rtl/sdram_rom_server_rom_port_slot.sv
// rom_port_slot
//   Per-requester bookkeeping: pending flag, latched request address and the
//   output data register.
//   clk_sys, reset  : clock and async active-high reset
//   req, addr       : request pulse and address from the game side
//   load_en         : ROM download active, requests are dropped
//   grant           : arbiter picked this slot this cycle (clears pending)
//   capture         : read data for this slot is valid this cycle
//   capture_data    : data to store on capture
//   pending, addr_q : request bookkeeping seen by the arbiter
//   data_q          : output data register, changes only on capture
module rom_port_slot #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load_en,
  input  logic              grant,
  input  logic              capture,
  input  logic [DATA_W-1:0] capture_data,
  output logic              pending,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] data_q
);

  // A new accepted request beats a same-cycle grant: the arbiter has already
  // copied the old address out, so the new one becomes a fresh transaction.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (req && !load_en) begin
        pending <= 1'b1;
        addr_q  <= addr;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (capture) begin
        data_q <= capture_data;
      end
    end
  end

endmodule

// File: rtl/sdram_rom_server.sv
// sdram_rom_server
//   Arbitrates four game ROM readers (68k program, tiles, sprites, theme)
//   onto one SDRAM read bus with fixed priority m68k > tiles > spr > theme.
//   clk_sys, reset        : system clock, async active-high reset
//   load_en               : HPS ROM download active; no new requests/grants
//   m68k_rom_req/addr     : 68k request pulse, 16-bit word address
//   m68k_rom_dout         : 68k read data (selected half of the 32-bit word)
//   sdram_dtack           : high when no 68k read is pending or in flight
//   tiles/spr/theme_rom_* : request pulse, word address, 32-bit read data
//   mem                   : SDRAM-side read bus (master modport)
module sdram_rom_server
  import sdram_rom_server_pkg::*;
#(
  parameter logic [23:0] M68K_BASE  = DEF_M68K_BASE,
  parameter logic [23:0] TILES_BASE = DEF_TILES_BASE,
  parameter logic [23:0] SPR_BASE   = DEF_SPR_BASE,
  parameter logic [23:0] THEME_BASE = DEF_THEME_BASE
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_en,

  input  logic        m68k_rom_req,
  input  logic [17:0] m68k_rom_addr,
  output logic [15:0] m68k_rom_dout,
  output logic        sdram_dtack,

  input  logic        tiles_rom_req,
  input  logic [17:0] tiles_rom_addr,
  output logic [31:0] tiles_rom_dout,

  input  logic        spr_rom_req,
  input  logic [18:0] spr_rom_addr,
  output logic [31:0] spr_rom_dout,

  input  logic        theme_rom_req,
  input  logic [17:0] theme_rom_addr,
  output logic [31:0] theme_rom_dout,

  sdram_rom_server_if.master mem
);

  state_t                 state;
  port_t                  active;
  logic                   m68k_hi;

  logic [NUM_PORTS-1:0]   pending;
  logic [NUM_PORTS-1:0]   grant;
  logic [NUM_PORTS-1:0]   capture;
  logic                   grant_any;
  port_t                  grant_port;
  logic [MEM_ADDR_W-1:0]  grant_addr;

  logic [17:0]            m68k_addr_q;
  logic [17:0]            tiles_addr_q;
  logic [18:0]            spr_addr_q;
  logic [17:0]            theme_addr_q;
  logic [15:0]            m68k_capture_data;

  // Fixed-priority pick among pending ports; only in IDLE and only while no
  // ROM download is running.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = M68K;
    grant      = '0;
    if (state == IDLE && !load_en) begin
      if (pending[M68K]) begin
        grant_any    = 1'b1;
        grant_port   = M68K;
        grant[M68K]  = 1'b1;
      end else if (pending[TILES]) begin
        grant_any    = 1'b1;
        grant_port   = TILES;
        grant[TILES] = 1'b1;
      end else if (pending[SPR]) begin
        grant_any    = 1'b1;
        grant_port   = SPR;
        grant[SPR]   = 1'b1;
      end else if (pending[THEME]) begin
        grant_any    = 1'b1;
        grant_port   = THEME;
        grant[THEME] = 1'b1;
      end
    end
  end

  // The 68k address is in 16-bit words, so drop bit 0 to get the 32-bit word.
  always_comb begin
    grant_addr = '0;
    case (grant_port)
      M68K:    grant_addr = region_addr(M68K_BASE,  {7'd0, m68k_addr_q[17:1]});
      TILES:   grant_addr = region_addr(TILES_BASE, {6'd0, tiles_addr_q});
      SPR:     grant_addr = region_addr(SPR_BASE,   {5'd0, spr_addr_q});
      THEME:   grant_addr = region_addr(THEME_BASE, {6'd0, theme_addr_q});
      default: grant_addr = '0;
    endcase
  end

  // mem_rdy is only meaningful while a request is on the bus.
  always_comb begin
    capture = '0;
    if (state == ISSUE && mem.mem_rdy) begin
      capture[active] = 1'b1;
    end
  end

  // Half select uses the bit frozen at grant time, since a new 68k request
  // during the flight may already have overwritten the latched address.
  assign m68k_capture_data = m68k_hi ? mem.mem_dout[31:16] : mem.mem_dout[15:0];

  // Arbiter FSM with registered bus outputs and 68k DTACK.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      active       <= M68K;
      m68k_hi      <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      sdram_dtack  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            state        <= ISSUE;
            active       <= grant_port;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= grant_addr;
            if (grant_port == M68K) begin
              m68k_hi <= m68k_addr_q[0];
            end
          end
        end
        ISSUE: begin
          if (mem.mem_rdy) begin
            state       <= DONE;
            mem.mem_req <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase

      // DTACK stays low across a re-request made while the first is in flight.
      if (m68k_rom_req && !load_en) begin
        sdram_dtack <= 1'b0;
      end else if (capture[M68K] && !pending[M68K]) begin
        sdram_dtack <= 1'b1;
      end
    end
  end

  rom_port_slot #(.ADDR_W(18), .DATA_W(16)) u_m68k_slot (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req          (m68k_rom_req),
    .addr         (m68k_rom_addr),
    .load_en      (load_en),
    .grant        (grant[M68K]),
    .capture      (capture[M68K]),
    .capture_data (m68k_capture_data),
    .pending      (pending[M68K]),
    .addr_q       (m68k_addr_q),
    .data_q       (m68k_rom_dout)
  );

  rom_port_slot #(.ADDR_W(18), .DATA_W(32)) u_tiles_slot (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req          (tiles_rom_req),
    .addr         (tiles_rom_addr),
    .load_en      (load_en),
    .grant        (grant[TILES]),
    .capture      (capture[TILES]),
    .capture_data (mem.mem_dout),
    .pending      (pending[TILES]),
    .addr_q       (tiles_addr_q),
    .data_q       (tiles_rom_dout)
  );

  rom_port_slot #(.ADDR_W(19), .DATA_W(32)) u_spr_slot (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req          (spr_rom_req),
    .addr         (spr_rom_addr),
    .load_en      (load_en),
    .grant        (grant[SPR]),
    .capture      (capture[SPR]),
    .capture_data (mem.mem_dout),
    .pending      (pending[SPR]),
    .addr_q       (spr_addr_q),
    .data_q       (spr_rom_dout)
  );

  rom_port_slot #(.ADDR_W(18), .DATA_W(32)) u_theme_slot (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .req          (theme_rom_req),
    .addr         (theme_rom_addr),
    .load_en      (load_en),
    .grant        (grant[THEME]),
    .capture      (capture[THEME]),
    .capture_data (mem.mem_dout),
    .pending      (pending[THEME]),
    .addr_q       (theme_addr_q),
    .data_q       (theme_rom_dout)
  );

endmodule

// File: tb/tb_sdram_rom_server.sv
// tb_sdram_rom_server
//   Self-checking bench for sdram_rom_server: a table of single-transaction
//   vectors with hand-computed SDRAM addresses and read data, plus directed
//   sequences for DTACK timing, priority, latest-wins, load_en and reset.
module tb_sdram_rom_server;
  import sdram_rom_server_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        load_en;
  logic        m68k_rom_req;
  logic [17:0] m68k_rom_addr;
  logic [15:0] m68k_rom_dout;
  logic        sdram_dtack;
  logic        tiles_rom_req;
  logic [17:0] tiles_rom_addr;
  logic [31:0] tiles_rom_dout;
  logic        spr_rom_req;
  logic [18:0] spr_rom_addr;
  logic [31:0] spr_rom_dout;
  logic        theme_rom_req;
  logic [17:0] theme_rom_addr;
  logic [31:0] theme_rom_dout;

  sdram_rom_server_if mem_bus ();

  sdram_rom_server dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .load_en        (load_en),
    .m68k_rom_req   (m68k_rom_req),
    .m68k_rom_addr  (m68k_rom_addr),
    .m68k_rom_dout  (m68k_rom_dout),
    .sdram_dtack    (sdram_dtack),
    .tiles_rom_req  (tiles_rom_req),
    .tiles_rom_addr (tiles_rom_addr),
    .tiles_rom_dout (tiles_rom_dout),
    .spr_rom_req    (spr_rom_req),
    .spr_rom_addr   (spr_rom_addr),
    .spr_rom_dout   (spr_rom_dout),
    .theme_rom_req  (theme_rom_req),
    .theme_rom_addr (theme_rom_addr),
    .theme_rom_dout (theme_rom_dout),
    .mem            (mem_bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    port_t       port;
    logic [18:0] addr;
    logic [31:0] data;
    int          delay;
    logic [23:0] exp_addr;
    logic [31:0] exp_dout;
  } vector_t;

  vector_t     vectors [9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_m68k, exp_tiles, exp_spr, exp_theme;
  logic [23:0] seen;

  bit dtack_count_en = 1'b0;
  int dtack_low_cnt  = 0;

  // Mid-cycle DTACK sampling so the count is the number of low cycles.
  always @(negedge clk_sys) begin
    if (dtack_count_en && !sdram_dtack) dtack_low_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic check_douts(input string tag);
    check_output({tag, "_m68k_dout"},  {16'h0, m68k_rom_dout}, exp_m68k);
    check_output({tag, "_tiles_dout"}, tiles_rom_dout, exp_tiles);
    check_output({tag, "_spr_dout"},   spr_rom_dout,   exp_spr);
    check_output({tag, "_theme_dout"}, theme_rom_dout, exp_theme);
  endtask

  task automatic update_model(input port_t p, input logic [31:0] v);
    case (p)
      M68K:    exp_m68k  = v;
      TILES:   exp_tiles = v;
      SPR:     exp_spr   = v;
      default: exp_theme = v;
    endcase
  endtask

  task automatic clear_reqs();
    m68k_rom_req  = 1'b0;
    tiles_rom_req = 1'b0;
    spr_rom_req   = 1'b0;
    theme_rom_req = 1'b0;
  endtask

  task automatic set_req(input port_t p, input logic [18:0] a);
    case (p)
      M68K:    begin m68k_rom_req  = 1'b1; m68k_rom_addr  = a[17:0]; end
      TILES:   begin tiles_rom_req = 1'b1; tiles_rom_addr = a[17:0]; end
      SPR:     begin spr_rom_req   = 1'b1; spr_rom_addr   = a;       end
      default: begin theme_rom_req = 1'b1; theme_rom_addr = a[17:0]; end
    endcase
  endtask

  task automatic apply_stimulus(input port_t p, input logic [18:0] a);
    set_req(p, a);
    tick();
    clear_reqs();
  endtask

  // Acts as the SDRAM controller for one read: waits for mem_req, then
  // raises mem_rdy 'delay' cycles after mem_req was first seen.
  task automatic serve(input int delay, input logic [31:0] data,
                       output logic [23:0] addr_seen);
    int waited = 0;
    addr_seen = '0;
    while (!mem_bus.mem_req && waited < 20) begin
      tick();
      waited++;
    end
    if (!mem_bus.mem_req) begin
      check_output("mem_req_timeout", 32'd0, 32'd1);
      return;
    end
    addr_seen = mem_bus.mem_addr;
    repeat (delay) tick();
    check_output("mem_req_held", {31'd0, mem_bus.mem_req}, 32'd1);
    mem_bus.mem_rdy  = 1'b1;
    mem_bus.mem_dout = data;
    tick();
    mem_bus.mem_rdy  = 1'b0;
    mem_bus.mem_dout = 32'h0;
    check_output("mem_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
  endtask

  task automatic no_req_window(input int n, input string name);
    int hits = 0;
    repeat (n) begin
      tick();
      if (mem_bus.mem_req) hits++;
    end
    check_output(name, hits, 32'd0);
  endtask

  initial begin
    vectors[0] = '{M68K,  19'h00000, 32'h11112222, 0, 24'h000000, 32'h00002222};
    vectors[1] = '{M68K,  19'h3FFFF, 32'hAAAA5555, 1, 24'h01FFFF, 32'h0000AAAA};
    vectors[2] = '{M68K,  19'h00010, 32'h0BADF00D, 2, 24'h000008, 32'h0000F00D};
    vectors[3] = '{TILES, 19'h00000, 32'h01020304, 0, 24'h040000, 32'h01020304};
    vectors[4] = '{TILES, 19'h3FFFF, 32'hCAFEBABE, 3, 24'h07FFFF, 32'hCAFEBABE};
    vectors[5] = '{SPR,   19'h7FFFF, 32'h12345678, 1, 24'h0FFFFF, 32'h12345678};
    vectors[6] = '{SPR,   19'h00001, 32'h87654321, 0, 24'h080001, 32'h87654321};
    vectors[7] = '{THEME, 19'h3FFFF, 32'hDEADBEEF, 2, 24'h13FFFF, 32'hDEADBEEF};
    vectors[8] = '{THEME, 19'h00123, 32'h5A5A0F0F, 1, 24'h100123, 32'h5A5A0F0F};

    reset = 1'b1;
    load_en = 1'b0;
    clear_reqs();
    m68k_rom_addr = '0; tiles_rom_addr = '0; spr_rom_addr = '0; theme_rom_addr = '0;
    mem_bus.mem_rdy = 1'b0;
    mem_bus.mem_dout = 32'h0;
    exp_m68k = '0; exp_tiles = '0; exp_spr = '0; exp_theme = '0;

    $display("[TB] reset state");
    repeat (3) tick();
    check_output("rst_mem_req",  {31'd0, mem_bus.mem_req}, 32'd0);
    check_output("rst_mem_addr", {8'd0, mem_bus.mem_addr}, 32'd0);
    check_output("rst_dtack",    {31'd0, sdram_dtack}, 32'd1);
    check_douts("rst");
    reset = 1'b0;
    tick();

    $display("[TB] m68k read with DTACK timing");
    dtack_low_cnt = 0;
    dtack_count_en = 1'b1;
    apply_stimulus(M68K, 19'h00005);
    check_output("dtack_fall", {31'd0, sdram_dtack}, 32'd0);
    serve(4, 32'hBEEF1234, seen);
    check_output("dtack_rise", {31'd0, sdram_dtack}, 32'd1);
    repeat (3) tick();
    dtack_count_en = 1'b0;
    check_output("m68k_mem_addr", {8'd0, seen}, 32'h000002);
    exp_m68k = 32'h0000BEEF;
    check_douts("m68k_odd");
    check_output("dtack_low_cycles", dtack_low_cnt, 32'd6);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vectors[i].port, vectors[i].addr);
      serve(vectors[i].delay, vectors[i].data, seen);
      check_output($sformatf("vec%0d_mem_addr", i), {8'd0, seen}, {8'd0, vectors[i].exp_addr});
      update_model(vectors[i].port, vectors[i].exp_dout);
      check_douts($sformatf("vec%0d", i));
      check_output($sformatf("vec%0d_dtack", i), {31'd0, sdram_dtack}, 32'd1);
      repeat (2) tick();
    end

    $display("[TB] simultaneous requests, priority order");
    set_req(M68K, 19'h00002);
    set_req(TILES, 19'h00010);
    set_req(SPR, 19'h00100);
    tick();
    clear_reqs();
    serve(1, 32'h1111AAAA, seen);
    check_output("prio1_addr", {8'd0, seen}, 32'h000001);
    exp_m68k = 32'h0000AAAA;
    check_douts("prio1");
    serve(0, 32'h2222BBBB, seen);
    check_output("prio2_addr", {8'd0, seen}, 32'h040010);
    exp_tiles = 32'h2222BBBB;
    check_douts("prio2");
    serve(2, 32'h3333CCCC, seen);
    check_output("prio3_addr", {8'd0, seen}, 32'h080100);
    exp_spr = 32'h3333CCCC;
    check_douts("prio3");
    repeat (2) tick();

    $display("[TB] latest-wins on pending spr");
    apply_stimulus(TILES, 19'h00004);
    apply_stimulus(SPR, 19'h00010);
    apply_stimulus(SPR, 19'h00020);
    serve(1, 32'h44444444, seen);
    check_output("lw_tiles_addr", {8'd0, seen}, 32'h040004);
    exp_tiles = 32'h44444444;
    serve(1, 32'h55555555, seen);
    check_output("lw_spr_addr", {8'd0, seen}, 32'h080020);
    exp_spr = 32'h55555555;
    check_douts("lw");
    no_req_window(8, "lw_spr_issued_once");

    $display("[TB] load_en behaviour");
    load_en = 1'b1;
    apply_stimulus(THEME, 19'h00007);
    no_req_window(6, "load_drop_during");
    load_en = 1'b0;
    no_req_window(4, "load_drop_after");
    apply_stimulus(THEME, 19'h00008);
    tick();
    check_output("load_inflight_req", {31'd0, mem_bus.mem_req}, 32'd1);
    load_en = 1'b1;
    serve(2, 32'h66666666, seen);
    check_output("load_inflight_addr", {8'd0, seen}, 32'h100008);
    exp_theme = 32'h66666666;
    check_douts("load_inflight");
    no_req_window(4, "load_no_grant");
    load_en = 1'b0;
    tick();

    apply_stimulus(TILES, 19'h00009);
    load_en = 1'b1;
    no_req_window(6, "pending_hold");
    load_en = 1'b0;
    serve(0, 32'h77777777, seen);
    check_output("pending_survive_addr", {8'd0, seen}, 32'h040009);
    exp_tiles = 32'h77777777;
    check_douts("pending_survive");
    repeat (2) tick();

    $display("[TB] stray mem_rdy in IDLE");
    mem_bus.mem_rdy = 1'b1;
    mem_bus.mem_dout = 32'hFFFFFFFF;
    tick();
    mem_bus.mem_rdy = 1'b0;
    mem_bus.mem_dout = 32'h0;
    tick();
    check_douts("stray");
    check_output("stray_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);

    $display("[TB] reset during ISSUE");
    apply_stimulus(M68K, 19'h00006);
    tick();
    check_output("rst_mid_req", {31'd0, mem_bus.mem_req}, 32'd1);
    check_output("rst_mid_dtack", {31'd0, sdram_dtack}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_bus.mem_rdy = 1'b1;
    mem_bus.mem_dout = 32'h12345678;
    tick();
    mem_bus.mem_rdy = 1'b0;
    mem_bus.mem_dout = 32'h0;
    tick();
    exp_m68k = '0; exp_tiles = '0; exp_spr = '0; exp_theme = '0;
    check_douts("rst_mid");
    check_output("rst_mid_mem_req_after", {31'd0, mem_bus.mem_req}, 32'd0);
    check_output("rst_mid_mem_addr", {8'd0, mem_bus.mem_addr}, 32'd0);
    check_output("rst_mid_dtack_after", {31'd0, sdram_dtack}, 32'd1);
    no_req_window(4, "rst_mid_no_req");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_rom_server.md
SDRAM_ROM_SERVER -- requirements
Module: sdram_rom_server

Interface
REQ-001 Parameter M68K_BASE, 24'h000000: 32-bit-word base address of the 68k program ROM region.
REQ-002 Parameter TILES_BASE, 24'h040000: word base address of the tile ROM region.
REQ-003 Parameter SPR_BASE, 24'h080000: word base address of the sprite ROM region.
REQ-004 Parameter THEME_BASE, 24'h100000: word base address of the theme/sample ROM region.
REQ-005 clk_sys  in  1  system clock, 96 MHz.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 load_en  in  1  HPS ROM download active; game requests are inhibited.
REQ-008 m68k_rom_req  in  1  one-cycle request pulse; m68k_rom_addr  in  18  16-bit word address.
REQ-009 m68k_rom_dout  out  16  read data; sdram_dtack  out  1  high = no 68k read pending.
REQ-010 tiles_rom_req  in  1; tiles_rom_addr  in  18; tiles_rom_dout  out  32.
REQ-011 spr_rom_req  in  1; spr_rom_addr  in  19; spr_rom_dout  out  32.
REQ-012 theme_rom_req  in  1; theme_rom_addr  in  18; theme_rom_dout  out  32.
REQ-013 mem_req  out  1; mem_addr  out  24  word address; mem_rdy  in  1  one-cycle data-valid strobe; mem_dout  in  32.

Function
REQ-014 Each port SHALL latch its address and set a pending flag on the clk_sys edge where its req pulse is high and load_en is low.
REQ-015 A req pulse on an already-pending, not-yet-granted port SHALL overwrite the latched address (latest wins).
REQ-016 A req pulse on the port currently in flight SHALL set pending again for a new transaction after completion.
REQ-017 Req pulses while load_en is high SHALL be dropped.
REQ-018 FSM states: IDLE, ISSUE, DONE.
REQ-019 IDLE: when any port is pending, grant with fixed priority m68k > tiles > spr > theme, clear that pending flag, go to ISSUE on the next edge.
REQ-020 ISSUE: mem_req=1 and mem_addr stable; on mem_rdy=1, capture mem_dout into the granted port and go to DONE.
REQ-021 DONE: mem_req=0 for one cycle, then return to IDLE; minimum request-to-request spacing is 3 cycles.
REQ-022 mem_addr for m68k SHALL be M68K_BASE + m68k_rom_addr[17:1].
REQ-023 m68k_rom_dout SHALL be mem_dout[15:0] when m68k_rom_addr[0]=0, else mem_dout[31:16].
REQ-024 mem_addr for the other ports SHALL be their base plus the zero-extended latched address; sums wrap modulo 2^24.
REQ-025 sdram_dtack SHALL fall on the edge after an accepted m68k req, stay low while m68k is pending or in flight, and rise on the edge that updates m68k_rom_dout.
REQ-026 Output data registers SHALL change only on their own port's mem_rdy capture and hold their value otherwise.
REQ-027 load_en rising SHALL NOT abort an in-flight transaction; no new grant SHALL occur while load_en=1; pending flags survive.
REQ-028 mem_rdy outside ISSUE SHALL be ignored.

Reset
REQ-029 On reset: FSM=IDLE, all pending flags 0, mem_req=0, mem_addr=0, all dout registers 0, sdram_dtack=1.
REQ-030 Reset asserted mid-transaction SHALL drop it immediately; no capture occurs after deassertion.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the port-index enum (M68K, TILES, SPR, THEME) and the default base-address constants.
REQ-032 One sub-module rom_port_slot (pending flag, address latch, data latch, grant/capture inputs) SHALL be instantiated four times.

Verification
REQ-033 m68k req, addr=18'h00005; mem_rdy 4 cycles after mem_req with mem_dout=32'hBEEF1234 -> mem_addr=24'h000002, m68k_rom_dout=16'hBEEF, sdram_dtack low for exactly 6 cycles.
REQ-034 tiles, spr and m68k req in the same cycle -> grant order m68k, tiles, spr; each dout updates only on its own capture.
REQ-035 spr req addr=19'h00010, then addr=19'h00020 one cycle later while tiles is in flight -> spr issued once with mem_addr=24'h080020.
REQ-036 theme req with load_en=1 -> mem_req stays 0; theme req with load_en=0 in flight when load_en rises -> completes, theme_rom_dout updated.
REQ-037 reset asserted during ISSUE, then mem_rdy pulsed after release -> all outputs at reset values, no capture, sdram_dtack=1.
REQ-038 stray mem_rdy in IDLE with mem_dout=32'hFFFFFFFF -> no dout changes.
